instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage with internal program store, branch
//             redirect, stall and halt. Optional retired-instruction counter
//             is built when INSTR_FETCH_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int IW    = 20,
    parameter int AW    = 9,
    parameter int DEPTH = 2**AW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [AW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          BrTaken,
    input  logic [AW-1:0] BrOffset,
    input  logic          Halt,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [IW-1:0] LdData,
    output logic [IW-1:0] Inst,
    output logic [AW-1:0] InstPC,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done,
    output logic [31:0]   InstCount
);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] inst_pc_q, inst_pc_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          inst_valid_q, inst_valid_d;

    logic [IW-1:0] mem [DEPTH];
    logic          w_rd_in_range;
    logic          w_ld_we;
    logic [IW-1:0] w_rd_data;

    // Addresses beyond DEPTH read as zero; the store itself has no reset.
    assign w_rd_in_range = (32'(pc_q) < $unsigned(DEPTH));
    assign w_rd_data     = w_rd_in_range ? mem[pc_q[MW-1:0]] : '0;
    assign w_ld_we       = LdEn && (state_q != S_FETCH) && (32'(LdAddr) < $unsigned(DEPTH));

    always_ff @(posedge Clk) begin
        if (w_ld_we) begin
            mem[LdAddr[MW-1:0]] <= LdData;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            S_FETCH: begin
                if (!Stall) begin
                    // Halt outranks a branch presented on the same cycle.
                    if (Halt && inst_valid_q) begin
                        state_d      = S_HALTED;
                        inst_valid_d = 1'b0;
                    end else if (BrTaken && inst_valid_q) begin
                        pc_d         = inst_pc_q + BrOffset;
                        inst_valid_d = 1'b0;
                    end else begin
                        inst_d       = w_rd_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + AW'(1);
                    end
                end
            end
            default: begin
                if (Start) begin
                    state_d      = S_FETCH;
                    pc_d         = StartAddr;
                    inst_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

`ifdef INSTR_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inst_valid_q && !Stall) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign InstCount = cnt_q;
`else
    assign InstCount = 32'd0;
`endif

    assign Inst      = inst_q;
    assign InstPC    = inst_pc_q;
    assign InstValid = inst_valid_q;
    assign Busy      = (state_q == S_FETCH);
    assign Done      = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed vector bench for instr_fetch (DEPTH 512 and 300).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
`ifdef INSTR_FETCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        Clk, Reset_n, Start, Stall, BrTaken, Halt, LdEn;
    logic [8:0]  StartAddr, BrOffset, LdAddr;
    logic [19:0] LdData;
    logic [19:0] Inst, Inst3;
    logic [8:0]  InstPC, InstPC3;
    logic        InstValid, Busy, Done, InstValid3, Busy3, Done3;
    logic [31:0] InstCount, InstCount3;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.IW(20), .AW(9)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .BrTaken(BrTaken), .BrOffset(BrOffset), .Halt(Halt),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
        .Inst(Inst), .InstPC(InstPC), .InstValid(InstValid),
        .Busy(Busy), .Done(Done), .InstCount(InstCount)
    );

    instr_fetch #(.IW(20), .AW(9), .DEPTH(300)) dut300 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .BrTaken(BrTaken), .BrOffset(BrOffset), .Halt(Halt),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
        .Inst(Inst3), .InstPC(InstPC3), .InstValid(InstValid3),
        .Busy(Busy3), .Done(Done3), .InstCount(InstCount3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        start;
        logic [8:0]  saddr;
        logic        stall, br;
        logic [8:0]  off;
        logic        halt, lden;
        logic [8:0]  laddr;
        logic [19:0] ldata;
        logic        ev, eb, ed, chk;
        logic [19:0] ei;
        logic [8:0]  ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [8:0] sa, logic stl, logic br, logic [8:0] off,
                                logic hlt, logic ld, logic [8:0] la, logic [19:0] ldd,
                                logic ev, logic eb, logic ed, logic chk, logic [19:0] ei, logic [8:0] ep);
        vec_t v;
        v.start = st; v.saddr = sa; v.stall = stl; v.br = br; v.off = off;
        v.halt = hlt; v.lden = ld; v.laddr = la; v.ldata = ldd;
        v.ev = ev; v.eb = eb; v.ed = ed; v.chk = chk; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clr_in();
        Start = 0; StartAddr = 0; Stall = 0; BrTaken = 0; BrOffset = 0;
        Halt = 0; LdEn = 0; LdAddr = 0; LdData = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".inst"},  32'(Inst), 32'd0);
        chk({tag, ".pc"},    32'(InstPC), 32'd0);
        chk({tag, ".valid"}, 32'(InstValid), 32'd0);
        chk({tag, ".busy"},  32'(Busy), 32'd0);
        chk({tag, ".done"},  32'(Done), 32'd0);
        chk({tag, ".cnt"},   InstCount, 32'd0);
    endtask

    logic [31:0] cnt_model;
    logic        prev_ev;

    initial begin
        clr_in();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Program image: mem[i] = i + 1
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            clr_in(); LdEn = 1; LdAddr = 9'(i); LdData = 20'(i + 1);
        end
        @(negedge Clk);
        clr_in();

        //           st sa     stl br off     hlt ld la  ldata      ev eb ed chk ei        ep
        tbl.push_back(mk(1, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     0, 1, 0, 0, 20'h0,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h1,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h2,     9'd1));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h3,     9'd2));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h4,     9'd3));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h5,     9'd4));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h6,     9'd5));
        tbl.push_back(mk(0, 9'd0,  0, 1, 9'h1FD, 0, 0, 9'd0, 20'h0,     0, 1, 0, 0, 20'h0,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h3,     9'd2));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h4,     9'd3));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h5,     9'd4));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h6,     9'd5));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h7,     9'd6));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h8,     9'd7));
        tbl.push_back(mk(0, 9'd0,  1, 0, 9'd0,   1, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h8,     9'd7));
        tbl.push_back(mk(0, 9'd0,  1, 1, 9'h010, 0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h8,     9'd7));
        tbl.push_back(mk(1, 9'h20, 1, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h8,     9'd7));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h9,     9'd8));
        tbl.push_back(mk(1, 9'h20, 0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'hA,     9'd9));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 1, 9'd3, 20'hFFFFF, 1, 1, 0, 1, 20'hB,     9'd10));
        tbl.push_back(mk(0, 9'd0,  0, 1, 9'h1FD, 1, 0, 9'd0, 20'h0,     0, 0, 1, 0, 20'h0,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     0, 0, 1, 0, 20'h0,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 1, 9'd4, 20'h77777, 0, 0, 1, 0, 20'h0,     9'd0));
        tbl.push_back(mk(1, 9'd2,  0, 0, 9'd0,   0, 1, 9'd2, 20'h12345, 0, 1, 0, 0, 20'h0,     9'd0));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h12345, 9'd2));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h4,     9'd3));
        tbl.push_back(mk(0, 9'd0,  0, 0, 9'd0,   0, 0, 9'd0, 20'h0,     1, 1, 0, 1, 20'h77777, 9'd4));

        cnt_model = 32'd0;
        prev_ev   = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            Start = tbl[i].start; StartAddr = tbl[i].saddr; Stall = tbl[i].stall;
            BrTaken = tbl[i].br; BrOffset = tbl[i].off; Halt = tbl[i].halt;
            LdEn = tbl[i].lden; LdAddr = tbl[i].laddr; LdData = tbl[i].ldata;
            if (prev_ev && !tbl[i].stall) cnt_model = cnt_model + 32'd1;
            tick();
            chk($sformatf("r%0d.valid", i), 32'(InstValid), 32'(tbl[i].ev));
            chk($sformatf("r%0d.busy", i),  32'(Busy),      32'(tbl[i].eb));
            chk($sformatf("r%0d.done", i),  32'(Done),      32'(tbl[i].ed));
            chk($sformatf("r%0d.cnt", i),   InstCount,      CNT_ON ? cnt_model : 32'd0);
            if (tbl[i].chk) begin
                chk($sformatf("r%0d.inst", i), 32'(Inst),   32'(tbl[i].ei));
                chk($sformatf("r%0d.pc", i),   32'(InstPC), 32'(tbl[i].ep));
            end
            prev_ev = tbl[i].ev;
        end

        // Upper boundary of a 300-word store
        @(negedge Clk); clr_in(); Halt = 1; tick();
        chk("b300.halt.done", 32'(Done3), 32'd1);
        @(negedge Clk); clr_in(); LdEn = 1; LdAddr = 9'd299; LdData = 20'hABCDE; tick();
        @(negedge Clk); clr_in(); Start = 1; StartAddr = 9'd299; tick();
        @(negedge Clk); clr_in(); tick();
        chk("b300.inst299", 32'(Inst3), 32'hABCDE);
        chk("b300.pc299",   32'(InstPC3), 32'd299);
        chk("b300.valid299", 32'(InstValid3), 32'd1);
        @(negedge Clk); clr_in(); tick();
        chk("b300.inst300", 32'(Inst3), 32'd0);
        chk("b300.pc300",   32'(InstPC3), 32'd300);
        chk("b512.pc300",   32'(InstPC), 32'd300);

        // PC wrap from 511 to 0
        @(negedge Clk); clr_in(); Halt = 1; tick();
        @(negedge Clk); clr_in(); LdEn = 1; LdAddr = 9'd511; LdData = 20'h5A5A5; tick();
        @(negedge Clk); clr_in(); Start = 1; StartAddr = 9'd511; tick();
        @(negedge Clk); clr_in(); tick();
        chk("wrap.inst511", 32'(Inst), 32'h5A5A5);
        chk("wrap.pc511",   32'(InstPC), 32'd511);
        chk("wrap300.inst511", 32'(Inst3), 32'd0);
        @(negedge Clk); clr_in(); tick();
        chk("wrap.inst0", 32'(Inst), 32'd1);
        chk("wrap.pc0",   32'(InstPC), 32'd0);
        chk("wrap300.inst0", 32'(Inst3), 32'd1);

        // Asynchronous reset in the middle of fetching
        #2;
        Reset_n = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); clr_in(); tick();
            chk($sformatf("post%0d.valid", k), 32'(InstValid), 32'd0);
            chk($sformatf("post%0d.busy", k),  32'(Busy), 32'd0);
        end
        @(negedge Clk); clr_in(); Start = 1; StartAddr = 9'd0; tick();
        @(negedge Clk); clr_in(); tick();
        chk("restart.inst", 32'(Inst), 32'd1);
        chk("restart.pc",   32'(InstPC), 32'd0);
        chk("restart.cnt",  InstCount, 32'd0);
        @(negedge Clk); clr_in(); tick();
        chk("restart.inst1", 32'(Inst), 32'd2);
        chk("restart.cnt1",  InstCount, CNT_ON ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
